// File: rtl/data_bus_responder_pkg.sv
// Shared constants, types and helpers for the CPU data-bus responder.
//   Store length codes, MMIO register offsets, STATUS bit indices,
//   address-region enum, byte-lane and misalignment helpers.
package data_bus_responder_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] BUS_LEN_BYTE = 3'b001;
  localparam logic [2:0] BUS_LEN_HALF = 3'b010;
  localparam logic [2:0] BUS_LEN_WORD = 3'b100;

  localparam logic [3:0] MMIO_OFF_TX     = 4'h0;
  localparam logic [3:0] MMIO_OFF_STATUS = 4'h4;
  localparam logic [3:0] MMIO_OFF_CYCLE  = 4'h8;

  localparam int unsigned STATUS_EMPTY_BIT    = 0;
  localparam int unsigned STATUS_FULL_BIT     = 1;
  localparam int unsigned STATUS_OVERFLOW_BIT = 2;

  typedef enum logic [1:0] {
    REGION_NONE = 2'd0,
    REGION_RAM  = 2'd1,
    REGION_MMIO = 2'd2
  } region_e;

  // Byte-lane enables for a store; zero for misaligned or unknown lengths.
  function automatic logic [3:0] lane_mask(input logic [2:0] len, input logic [1:0] off);
    logic [3:0] mask;
    mask = 4'b0000;
    case (len)
      BUS_LEN_BYTE: mask = 4'b0001 << off;
      BUS_LEN_HALF: mask = off[0] ? 4'b0000 : (4'b0011 << off);
      BUS_LEN_WORD: mask = (off == 2'b00) ? 4'b1111 : 4'b0000;
      default:      mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] len, input logic [1:0] off);
    return ((len == BUS_LEN_HALF) && off[0]) || ((len == BUS_LEN_WORD) && (off != 2'b00));
  endfunction

  function automatic logic is_valid_len(input logic [2:0] len);
    return (len == BUS_LEN_BYTE) || (len == BUS_LEN_HALF) || (len == BUS_LEN_WORD);
  endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// CPU data-bus bundle between core (master) and responder (slave).
//   address/wr_data/wr_enable/write_length : core -> responder
//   read_data                             : responder -> core, combinational
interface data_bus_responder_if;
  import data_bus_responder_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wr_data;
  logic              wr_enable;
  logic [2:0]        write_length;
  logic [DATA_W-1:0] read_data;

  modport master (
    output address, wr_data, wr_enable, write_length,
    input  read_data
  );

  modport slave (
    input  address, wr_data, wr_enable, write_length,
    output read_data
  );
endinterface

// File: rtl/data_bus_responder_tx_fifo.sv
// Byte TX FIFO with sticky overflow and a valid/ready drain port.
//   i_push/i_push_data   : enqueue at edge (dropped when full without pop)
//   i_clr_overflow       : clear sticky overflow flag
//   o_data/o_valid/i_ready : head byte (8'h00 when empty), pop on valid&&ready
//   o_full/o_empty/o_overflow : status flags
module data_bus_responder_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_push,
  input  logic [7:0] i_push_data,
  input  logic       i_clr_overflow,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_overflow
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             pop_c;
  logic             push_ok_c;

  assign o_empty    = (count_q == '0);
  assign o_full     = (count_q == CNT_W'(DEPTH));
  assign o_valid    = !o_empty;
  assign o_overflow = overflow_q;
  assign o_data     = o_empty ? 8'h00 : mem_q[rd_ptr_q];

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push.
  assign pop_c     = o_valid && i_ready;
  assign push_ok_c = i_push && (!o_full || pop_c);

  // Next-state for pointers, occupancy and overflow.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (pop_c)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({push_ok_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (i_clr_overflow)               overflow_d = 1'b0;
    if (i_push && o_full && !pop_c)   overflow_d = 1'b1;
  end

  // Control state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the empty mux hides stale entries.
  always_ff @(posedge i_clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= i_push_data;
  end

endmodule

// File: rtl/data_bus_responder.sv
// Responder end of the single-cycle core's data bus.
//   i_clk, i_reset      : clock, async active-high reset
//   bus (slave)         : address/wr_data/wr_enable/write_length in, read_data out (combinational)
//   o_tx_data/o_tx_valid/i_tx_ready : TX FIFO drain port
//   o_misaligned        : sticky flag, a misaligned RAM store was suppressed
// Address map: word RAM at 0, MMIO window (TX_DATA, STATUS, CYCLE, reserved) at MMIO_BASE.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int unsigned RAM_WORDS     = 1024,
  parameter logic [31:0] MMIO_BASE     = 32'h1000_0000,
  parameter int unsigned TX_FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  data_bus_responder_if.slave  bus,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic                 o_misaligned
);
  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

  logic [DATA_W-1:0] ram_q [RAM_WORDS];
  logic [DATA_W-1:0] cycle_q, cycle_d;
  logic              misaligned_q, misaligned_d;

  region_e           region_c;
  logic [1:0]        off_c;
  logic [3:0]        mmio_off_c;
  logic [RAM_AW-1:0] ram_idx_c;
  logic              wr_en_c;
  logic [3:0]        ram_be_c;
  logic [DATA_W-1:0] wr_data_sh_c;
  logic [DATA_W-1:0] ram_word_c;
  logic              mmio_wr_c;
  logic              tx_push_c;
  logic              clr_ovf_c;
  logic              cyc_load_c;
  logic [DATA_W-1:0] read_data_c;
  logic              tx_full_c, tx_empty_c, tx_overflow_c;

  assign off_c      = bus.address[1:0];
  assign mmio_off_c = bus.address[3:0];
  assign ram_idx_c  = bus.address[RAM_AW+1:2];

  // Address decode.
  always_comb begin
    region_c = REGION_NONE;
    if (bus.address[ADDR_W-1:RAM_AW+2] == '0)
      region_c = REGION_RAM;
    else if (bus.address[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4])
      region_c = REGION_MMIO;
  end

  // A store arriving while reset is held is discarded, RAM included.
  assign wr_en_c      = bus.wr_enable && !i_reset;
  assign ram_be_c     = (wr_en_c && (region_c == REGION_RAM)) ? lane_mask(bus.write_length, off_c) : 4'b0000;
  assign wr_data_sh_c = bus.wr_data << {off_c, 3'b000};
  assign ram_word_c   = ram_q[ram_idx_c];

  assign mmio_wr_c  = wr_en_c && (region_c == REGION_MMIO) && (off_c == 2'b00) && is_valid_len(bus.write_length);
  assign tx_push_c  = mmio_wr_c && (mmio_off_c == MMIO_OFF_TX);
  assign clr_ovf_c  = mmio_wr_c && (mmio_off_c == MMIO_OFF_STATUS);
  assign cyc_load_c = mmio_wr_c && (mmio_off_c == MMIO_OFF_CYCLE) && (bus.write_length == BUS_LEN_WORD);

  // Counter and sticky-flag next state; a load overrides the increment.
  always_comb begin
    cycle_d      = cycle_q + DATA_W'(1);
    misaligned_d = misaligned_q;
    if (cyc_load_c) cycle_d = bus.wr_data;
    if (wr_en_c && (region_c == REGION_RAM) && is_misaligned(bus.write_length, off_c))
      misaligned_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cycle_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      cycle_q      <= cycle_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Byte-lane RAM write; contents are intentionally not reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_be_c[b]) ram_q[ram_idx_c][8*b +: 8] <= wr_data_sh_c[8*b +: 8];
    end
  end

  // Combinational read mux.
  always_comb begin
    read_data_c = '0;
    case (region_c)
      REGION_RAM: read_data_c = ram_word_c >> {off_c, 3'b000};
      REGION_MMIO: begin
        if (off_c == 2'b00) begin
          case (mmio_off_c)
            MMIO_OFF_STATUS: begin
              read_data_c[STATUS_EMPTY_BIT]    = tx_empty_c;
              read_data_c[STATUS_FULL_BIT]     = tx_full_c;
              read_data_c[STATUS_OVERFLOW_BIT] = tx_overflow_c;
            end
            MMIO_OFF_CYCLE: read_data_c = cycle_q;
            default:        read_data_c = '0;
          endcase
        end
      end
      default: read_data_c = '0;
    endcase
  end

  assign bus.read_data = read_data_c;
  assign o_misaligned  = misaligned_q;

  data_bus_responder_tx_fifo #(
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_push         (tx_push_c),
    .i_push_data    (bus.wr_data[7:0]),
    .i_clr_overflow (clr_ovf_c),
    .o_data         (o_tx_data),
    .o_valid        (o_tx_valid),
    .i_ready        (i_tx_ready),
    .o_full         (tx_full_c),
    .o_empty        (tx_empty_c),
    .o_overflow     (tx_overflow_c)
  );

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed self-checking bench for data_bus_responder.
module tb_data_bus_responder;
  localparam logic [31:0] A_TX     = 32'h1000_0000;
  localparam logic [31:0] A_STATUS = 32'h1000_0004;
  localparam logic [31:0] A_CYCLE  = 32'h1000_0008;
  localparam logic [2:0]  L_BYTE   = 3'b001;
  localparam logic [2:0]  L_HALF   = 3'b010;
  localparam logic [2:0]  L_WORD   = 3'b100;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       misaligned;
  int         tests;
  int         fails;

  data_bus_responder_if bus ();

  data_bus_responder dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .bus          (bus.slave),
    .o_tx_data    (tx_data),
    .o_tx_valid   (tx_valid),
    .i_tx_ready   (tx_ready),
    .o_misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Store committed at the next rising edge; returns 1 time unit after it.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] len);
    bus.address      = a;
    bus.wr_data      = d;
    bus.write_length = len;
    bus.wr_enable    = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_enable    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.address   = a;
    bus.wr_enable = 1'b0;
    #1;
    d = bus.read_data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;

  initial begin
    tests = 0;
    fails = 0;
    rst              = 1'b1;
    tx_ready         = 1'b0;
    bus.address      = 32'h0;
    bus.wr_data      = 32'h0;
    bus.wr_enable    = 1'b0;
    bus.write_length = 3'b000;
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_misaligned", 32'(misaligned), 32'h0);
    bus_read(A_CYCLE, rd);   check("rst_cycle", rd, 32'h0);
    bus_read(A_STATUS, rd);  check("rst_status", rd, 32'h1);
    rst = 1'b0;

    // 1: word store and offset reads
    bus_write(32'h10, 32'hDEADBEEF, L_WORD);
    bus_read(32'h10, rd); check("t1_rd10", rd, 32'hDEADBEEF);
    bus_read(32'h11, rd); check("t1_rd11", rd, 32'h00DEADBE);
    bus_read(32'h13, rd); check("t1_rd13", rd, 32'h000000DE);

    // 2: byte/half lanes, misaligned half suppressed
    bus_write(32'h20, 32'h0, L_WORD);
    bus_write(32'h21, 32'hFFFF_FFAA, L_BYTE);
    bus_write(32'h22, 32'hFFFF_1234, L_HALF);
    bus_read(32'h20, rd); check("t2_rd20", rd, 32'h1234AA00);
    check("t2_mis_before", 32'(misaligned), 32'h0);
    bus_write(32'h23, 32'h0000_5678, L_HALF);
    bus_read(32'h20, rd); check("t2_rd20_after", rd, 32'h1234AA00);
    check("t2_mis_after", 32'(misaligned), 32'h1);

    // unmapped / reserved / misaligned MMIO
    bus_write(32'h4000_0010, 32'h1111_1111, L_WORD);
    bus_read(32'h10, rd); check("unmapped_no_alias", rd, 32'hDEADBEEF);
    bus_read(32'h4000_0010, rd); check("unmapped_rd", rd, 32'h0);
    bus_read(32'h1000_000C, rd); check("reserved_rd", rd, 32'h0);
    bus_read(32'h1000_0009, rd); check("mmio_unaligned_rd", rd, 32'h0);
    bus_read(A_TX, rd); check("tx_rd_zero", rd, 32'h0);

    // 3: overflow, then drain
    for (int i = 1; i <= 5; i++) bus_write(A_TX, 32'(i), L_BYTE);
    bus_read(A_STATUS, rd); check("t3_status_full_ovf", rd, 32'h6);
    check("t3_head", 32'(tx_data), 32'h01);
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("t3_drain_valid", 32'(tx_valid), 32'h1);
      check("t3_drain_data", 32'(tx_data), 32'(i));
      step();
    end
    check("t3_empty_valid", 32'(tx_valid), 32'h0);
    check("t3_empty_data", 32'(tx_data), 32'h0);
    tx_ready = 1'b0;
    bus_read(A_STATUS, rd); check("t3_status_pre_clr", rd, 32'h5);
    bus_write(A_STATUS, 32'h0, L_WORD);
    bus_read(A_STATUS, rd); check("t3_status_clr", rd, 32'h1);

    // 4: push into full FIFO with simultaneous pop
    for (int i = 5; i <= 8; i++) bus_write(A_TX, 32'(i), L_BYTE);
    bus_read(A_STATUS, rd); check("t4_status_full", rd, 32'h2);
    tx_ready = 1'b1;
    bus_write(A_TX, 32'h09, L_BYTE);
    tx_ready = 1'b0;
    bus_read(A_STATUS, rd); check("t4_status_after", rd, 32'h2);
    check("t4_head", 32'(tx_data), 32'h06);
    tx_ready = 1'b1;
    for (int i = 6; i <= 9; i++) begin
      #1;
      check("t4_drain_data", 32'(tx_data), 32'(i));
      step();
    end
    check("t4_empty_valid", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // 5: cycle counter load and wrap; non-word write ignored
    bus_write(A_CYCLE, 32'hFFFF_FFFE, L_WORD);
    bus_read(A_CYCLE, rd); check("t5_cyc0", rd, 32'hFFFF_FFFE);
    step();
    bus_read(A_CYCLE, rd); check("t5_cyc1", rd, 32'hFFFF_FFFF);
    step();
    bus_read(A_CYCLE, rd); check("t5_cyc_wrap", rd, 32'h0);
    bus_write(A_CYCLE, 32'h0000_5555, L_HALF);
    bus_read(A_CYCLE, rd); check("t5_half_ignored", rd, 32'h1);

    // 6: async reset mid-drain
    bus_write(A_TX, 32'h11, L_BYTE);
    bus_write(A_TX, 32'h22, L_BYTE);
    bus_write(A_TX, 32'h33, L_BYTE);
    bus_write(A_TX, 32'h44, L_BYTE);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("t6_mid_head", 32'(tx_data), 32'h22);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(tx_valid), 32'h0);
    check("t6_rst_data", 32'(tx_data), 32'h0);
    check("t6_rst_mis", 32'(misaligned), 32'h0);
    bus_read(A_CYCLE, rd); check("t6_rst_cycle", rd, 32'h0);
    bus_read(32'h10, rd); check("t6_ram_kept", rd, 32'hDEADBEEF);
    // store held during reset must be lost
    bus_write(32'h10, 32'h0, L_WORD);
    bus_read(32'h10, rd); check("t6_store_in_reset", rd, 32'hDEADBEEF);
    bus_read(32'h20, rd); check("t6_ram20_kept", rd, 32'h1234AA00);
    rst = 1'b0;
    step();
    bus_read(A_CYCLE, rd); check("t6_cycle_restart", rd, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
